i2s_tx_ctrl: RTL and testbench

I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_clk_gen.sv | 81 ++++++++
 rtl/i2s_tx_ctrl.sv | 119 +++++++++++
 tb/tb_i2s_tx_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and helpers for the I2S transmitter
package i2s_pkg;

    localparam int DEF_PDATA_WIDTH = 32;
    localparam int DEF_SCLK_DIV    = 4;
    localparam int UNDERRUN_CNT_W  = 16;

    // Width of a counter that walks every bit slot of one stereo frame
    function automatic int bit_cnt_width(input int pdata_width);
        return $clog2(2 * pdata_width);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - SCLK divider, bit counter, word select and frame strobe
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int PDATA_WIDTH = DEF_PDATA_WIDTH,
    parameter int SCLK_DIV    = DEF_SCLK_DIV
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en_in,
    output logic sclk_out,
    output logic lrck_out,
    output logic frame_stb_out
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BC_W  = bit_cnt_width(PDATA_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * PDATA_WIDTH - 1);
    localparam logic [BC_W-1:0]  BC_HALF  = BC_W'(PDATA_WIDTH);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             lrck_q, lrck_d;
    logic             frame_stb;

    // Next-state: divide clk_in to SCLK, step the bit slot on each SCLK fall
    always_comb begin
        div_d     = div_q;
        sclk_d    = sclk_q;
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        frame_stb = 1'b0;
        if (!en_in) begin
            // Disabled: park everything so the next enable starts a fresh frame
            div_d     = '0;
            sclk_d    = 1'b0;
            bit_cnt_d = '0;
            lrck_d    = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (sclk_q) begin
                // Falling SCLK edge: advance the bit slot, wrap marks the frame boundary
                if (bit_cnt_q == BC_LAST) begin
                    bit_cnt_d = '0;
                    frame_stb = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BC_ONE;
                end
                lrck_d = (bit_cnt_d >= BC_HALF);
            end
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    // Timing state registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_q     <= '0;
            sclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
        end
    end

    assign sclk_out      = sclk_q;
    assign lrck_out      = lrck_q;
    assign frame_stb_out = frame_stb;

endmodule

// File: rtl/i2s_tx_ctrl.sv
// rtl/i2s_tx_ctrl.sv - I2S transmit controller: handshake, holding pair, underrun tracking
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int PDATA_WIDTH = DEF_PDATA_WIDTH,
    parameter int SCLK_DIV    = DEF_SCLK_DIV
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      en_in,
    input  logic                      clr_in,
    input  logic                      s_valid_in,
    input  logic [PDATA_WIDTH-1:0]    s_ldata_in,
    input  logic [PDATA_WIDTH-1:0]    s_rdata_in,
    output logic                      s_ready_out,
    output logic                      sclk_out,
    output logic                      lrck_out,
    output logic [PDATA_WIDTH-1:0]    pldata_out,
    output logic [PDATA_WIDTH-1:0]    prdata_out,
    output logic                      underrun_out,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_out
);

    localparam logic [UNDERRUN_CNT_W-1:0] CNT_ONE = UNDERRUN_CNT_W'(1);
    localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX = '1;

    logic                      frame_stb;
    logic                      xfer;

    logic [PDATA_WIDTH-1:0]    pend_l_q, pend_l_d;
    logic [PDATA_WIDTH-1:0]    pend_r_q, pend_r_d;
    logic                      pend_v_q, pend_v_d;
    logic [PDATA_WIDTH-1:0]    pldata_q, pldata_d;
    logic [PDATA_WIDTH-1:0]    prdata_q, prdata_d;
    logic                      underrun_q, underrun_d;
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

    i2s_clk_gen #(
        .PDATA_WIDTH (PDATA_WIDTH),
        .SCLK_DIV    (SCLK_DIV)
    ) u_clk_gen (
        .clk_in        (clk_in),
        .rst           (rst),
        .en_in         (en_in),
        .sclk_out      (sclk_out),
        .lrck_out      (lrck_out),
        .frame_stb_out (frame_stb)
    );

    // Ready comes only from registered state and the enable, never from s_valid_in
    assign s_ready_out = en_in & ~rst & ~pend_v_q;
    assign xfer        = s_valid_in & s_ready_out;

    // Next-state: boundary consumes the old pending pair before any same-cycle transfer lands
    always_comb begin
        pend_l_d       = pend_l_q;
        pend_r_d       = pend_r_q;
        pend_v_d       = pend_v_q;
        pldata_d       = pldata_q;
        prdata_d       = prdata_q;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;

        if (frame_stb) begin
            if (pend_v_q) begin
                pldata_d = pend_l_q;
                prdata_d = pend_r_q;
                pend_v_d = 1'b0;
            end else begin
                // Nothing queued for this frame: play silence and record the starvation
                pldata_d   = '0;
                prdata_d   = '0;
                underrun_d = 1'b1;
                if (underrun_cnt_q != CNT_MAX) begin
                    underrun_cnt_d = underrun_cnt_q + CNT_ONE;
                end
            end
        end

        // A pair accepted in the boundary cycle waits for the following frame
        if (xfer) begin
            pend_l_d = s_ldata_in;
            pend_r_d = s_rdata_in;
            pend_v_d = 1'b1;
        end

        // Clear beats a simultaneous underrun increment
        if (clr_in) begin
            underrun_cnt_d = '0;
        end
    end

    // Datapath and counter registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend_l_q       <= '0;
            pend_r_q       <= '0;
            pend_v_q       <= 1'b0;
            pldata_q       <= '0;
            prdata_q       <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            pend_l_q       <= pend_l_d;
            pend_r_q       <= pend_r_d;
            pend_v_q       <= pend_v_d;
            pldata_q       <= pldata_d;
            prdata_q       <= prdata_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign pldata_out       = pldata_q;
    assign prdata_out       = prdata_q;
    assign underrun_out     = underrun_q;
    assign underrun_cnt_out = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// tb/tb_i2s_tx_ctrl.sv - self-checking bench for i2s_tx_ctrl
module tb_i2s_tx_ctrl;

    localparam int PW    = 8;
    localparam int DIV   = 2;
    localparam int FRAME = 2 * DIV * 2 * PW;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          en_in = 1'b0;
    logic          clr_in = 1'b0;
    logic          s_valid_in = 1'b0;
    logic [PW-1:0] s_ldata_in = '0;
    logic [PW-1:0] s_rdata_in = '0;
    logic          s_ready_out;
    logic          sclk_out;
    logic          lrck_out;
    logic [PW-1:0] pldata_out;
    logic [PW-1:0] prdata_out;
    logic          underrun_out;
    logic [15:0]   underrun_cnt_out;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            t;
    bit            m_pv;
    logic [PW-1:0] m_pend_l, m_pend_r, m_pl, m_pr;
    bit            m_und;
    int unsigned   m_cnt;
    bit            m_xf;
    bit            chk_on = 1'b0;

    // stimulus state
    bit            fire;
    int            k;
    logic [PW-1:0] src_l[$];
    logic [PW-1:0] src_r[$];
    bit            allow = 1'b1;

    always #5 clk_in = ~clk_in;

    i2s_tx_ctrl #(
        .PDATA_WIDTH (PW),
        .SCLK_DIV    (DIV)
    ) dut (
        .clk_in           (clk_in),
        .rst              (rst),
        .en_in            (en_in),
        .clr_in           (clr_in),
        .s_valid_in       (s_valid_in),
        .s_ldata_in       (s_ldata_in),
        .s_rdata_in       (s_rdata_in),
        .s_ready_out      (s_ready_out),
        .sclk_out         (sclk_out),
        .lrck_out         (lrck_out),
        .pldata_out       (pldata_out),
        .prdata_out       (prdata_out),
        .underrun_out     (underrun_out),
        .underrun_cnt_out (underrun_cnt_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts enabled cycles; every FRAME-th one is a frame boundary
    always @(posedge clk_in) begin
        if (rst) begin
            t = 0; m_pv = 0; m_pend_l = '0; m_pend_r = '0;
            m_pl = '0; m_pr = '0; m_und = 0; m_cnt = 0;
        end else begin
            m_und = 0;
            m_xf  = en_in && s_valid_in && !m_pv;
            if (en_in) begin
                t++;
                if (t % FRAME == 0) begin
                    if (m_pv) begin
                        m_pl = m_pend_l; m_pr = m_pend_r; m_pv = 0;
                    end else begin
                        m_pl = '0; m_pr = '0; m_und = 1;
                        if (m_cnt < 32'hFFFF) m_cnt++;
                    end
                end
            end else begin
                t = 0;
            end
            if (clr_in) m_cnt = 0;
            if (m_xf) begin
                m_pend_l = s_ldata_in; m_pend_r = s_rdata_in; m_pv = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk_in) begin
        if (chk_on) begin
            check("sclk", 32'(sclk_out), 32'((t / DIV) % 2));
            check("lrck", 32'(lrck_out), 32'(((t / (2 * DIV)) % (2 * PW)) >= PW));
            check("pldata", 32'(pldata_out), 32'(m_pl));
            check("prdata", 32'(prdata_out), 32'(m_pr));
            check("underrun", 32'(underrun_out), 32'(m_und));
            check("underrun_cnt", 32'(underrun_cnt_out), m_cnt);
            check("s_ready", 32'(s_ready_out), 32'(en_in && !rst && !m_pv));
        end
    end

    task automatic drive_src();
        s_valid_in = allow && (src_l.size() > 0);
        if (src_l.size() > 0) begin
            s_ldata_in = src_l[0];
            s_rdata_in = src_r[0];
        end
    endtask

    task automatic step();
        #1;
        fire = s_valid_in && s_ready_out;
        @(posedge clk_in);
        #2;
        k++;
        if (fire && src_l.size() > 0) begin
            void'(src_l.pop_front());
            void'(src_r.pop_front());
        end
        drive_src();
    endtask

    task automatic run_until(input int target);
        while (k < target) step();
    endtask

    task automatic push(input logic [PW-1:0] l, input logic [PW-1:0] r);
        src_l.push_back(l);
        src_r.push_back(r);
        drive_src();
    endtask

    task automatic do_reset();
        rst = 1'b1; en_in = 1'b0; clr_in = 1'b0;
        src_l.delete(); src_r.delete(); allow = 1'b1;
        drive_src();
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic start();
        en_in = 1'b1;
        k = 0;
    endtask

    initial begin
        @(posedge clk_in);
        #2;
        // Reset state
        do_reset();
        rst = 1'b1;
        step();
        chk_on = 1'b1;
        check("rst_sclk", 32'(sclk_out), 0);
        check("rst_lrck", 32'(lrck_out), 0);
        check("rst_pl", 32'(pldata_out), 0);
        check("rst_cnt", 32'(underrun_cnt_out), 0);
        check("rst_ready", 32'(s_ready_out), 0);
        rst = 1'b0;
        step();

        // Timing and starvation
        start();
        run_until(1);   check("t1_sclk", 32'(sclk_out), 0);
        run_until(2);   check("t2_sclk", 32'(sclk_out), 1);
        run_until(4);   check("t4_sclk", 32'(sclk_out), 0);
        run_until(31);  check("t31_lrck", 32'(lrck_out), 0);
        run_until(32);  check("t32_lrck", 32'(lrck_out), 1);
        run_until(63);  check("t63_und", 32'(underrun_out), 0);
        run_until(64);  check("t64_lrck", 32'(lrck_out), 0);
        check("t64_und", 32'(underrun_out), 1);
        check("t64_cnt", 32'(underrun_cnt_out), 1);
        check("t64_pl", 32'(pldata_out), 0);
        run_until(65);  check("t65_und", 32'(underrun_out), 0);
        run_until(96);  check("t96_lrck", 32'(lrck_out), 1);
        run_until(128); check("t128_cnt", 32'(underrun_cnt_out), 2);

        // Steady stream
        do_reset();
        push(8'h11, 8'h22);
        push(8'h33, 8'h44);
        start();
        run_until(10);  check("st_ready_pending", 32'(s_ready_out), 0);
        run_until(63);  check("st_pl63", 32'(pldata_out), 0);
        run_until(64);  check("st_pl64", 32'(pldata_out), 32'h11);
        check("st_pr64", 32'(prdata_out), 32'h22);
        check("st_und64", 32'(underrun_out), 0);
        check("st_ready64", 32'(s_ready_out), 1);
        run_until(128); check("st_pl128", 32'(pldata_out), 32'h33);
        check("st_pr128", 32'(prdata_out), 32'h44);
        check("st_cnt128", 32'(underrun_cnt_out), 0);

        // Late pair lands exactly on the boundary
        do_reset();
        start();
        run_until(63);
        push(8'hAA, 8'hBB);
        run_until(64);  check("late_und", 32'(underrun_out), 1);
        check("late_cnt", 32'(underrun_cnt_out), 1);
        check("late_pl64", 32'(pldata_out), 0);
        check("late_ready", 32'(s_ready_out), 0);
        run_until(128); check("late_pl128", 32'(pldata_out), 32'hAA);
        check("late_pr128", 32'(prdata_out), 32'hBB);
        check("late_cnt128", 32'(underrun_cnt_out), 1);

        // Saturation and clear-wins
        do_reset();
        start();
        run_until(10);
        force dut.underrun_cnt_q = 16'hFFFD;
        m_cnt = 32'hFFFD;
        step();
        release dut.underrun_cnt_q;
        run_until(64);  check("sat_fffe", 32'(underrun_cnt_out), 32'hFFFE);
        run_until(128); check("sat_ffff", 32'(underrun_cnt_out), 32'hFFFF);
        run_until(192); check("sat_hold", 32'(underrun_cnt_out), 32'hFFFF);
        check("sat_und", 32'(underrun_out), 1);
        run_until(255);
        clr_in = 1'b1;
        run_until(256); check("clr_wins", 32'(underrun_cnt_out), 0);
        check("clr_und", 32'(underrun_out), 1);
        clr_in = 1'b0;

        // Disable mid-frame holds data and the pending pair
        do_reset();
        push(8'h55, 8'h66);
        push(8'h77, 8'h88);
        start();
        run_until(64);  check("dis_pl64", 32'(pldata_out), 32'h55);
        run_until(104); check("dis_lrck_before", 32'(lrck_out), 1);
        en_in = 1'b0;
        step();
        check("dis_sclk", 32'(sclk_out), 0);
        check("dis_lrck", 32'(lrck_out), 0);
        check("dis_ready", 32'(s_ready_out), 0);
        check("dis_pl_hold", 32'(pldata_out), 32'h55);
        repeat (20) step();
        check("dis_pr_hold", 32'(prdata_out), 32'h66);
        start();
        run_until(63);  check("re_pl63", 32'(pldata_out), 32'h55);
        run_until(64);  check("re_pl64", 32'(pldata_out), 32'h77);
        check("re_pr64", 32'(prdata_out), 32'h88);
        check("re_und64", 32'(underrun_out), 0);

        // Reset mid-frame discards the pending pair
        push(8'h99, 8'hAA);
        run_until(84);
        check("mrst_pending", 32'(s_ready_out), 0);
        rst = 1'b1;
        step();
        check("mrst_sclk", 32'(sclk_out), 0);
        check("mrst_lrck", 32'(lrck_out), 0);
        check("mrst_pl", 32'(pldata_out), 0);
        check("mrst_pr", 32'(prdata_out), 0);
        check("mrst_und", 32'(underrun_out), 0);
        check("mrst_ready", 32'(s_ready_out), 0);
        src_l.delete(); src_r.delete();
        drive_src();
        rst = 1'b0;
        k = 0;
        step();
        check("mrst_pend_clear", 32'(s_ready_out), 1);
        run_until(64);
        check("mrst_und64", 32'(underrun_out), 1);
        check("mrst_pl64", 32'(pldata_out), 0);

        // Randomized traffic, enables, clears and resets against the model
        do_reset();
        start();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en_in = ~en_in;
            clr_in = ($urandom_range(0, 499) == 0);
            rst    = ($urandom_range(0, 1499) == 0);
            allow  = ($urandom_range(0, 9) < 8);
            if (src_l.size() < 2 && $urandom_range(0, 69) == 0)
                push(PW'($urandom), PW'($urandom));
            drive_src();
            step();
        end
        rst = 1'b0; clr_in = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
